// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory access controller between a pipeline memory stage
// and a simple request/acknowledge external memory bus.
//
// A load or store from the pipeline is checked for legality (exactly one of
// cpu_rd/cpu_wr, word-aligned address). Legal accesses are latched and
// presented on the bus until bus_ack arrives or the wait budget runs out.
// Illegal accesses never reach the bus and are reported with mem_err.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   cpu_rd     in   1   load request
//   cpu_wr     in   1   store request
//   cpu_addr   in  32   byte address
//   cpu_wdata  in  32   store data
//   stall      out  1   freeze pipeline while high
//   mem_out    out 32   last successfully loaded word
//   mem_err    out  1   one-cycle pulse on a failed access
//   bus_req    out  1   external memory request
//   bus_we     out  1   1 = write, 0 = read
//   bus_addr   out 32   word-aligned address
//   bus_wdata  out 32   write data
//   bus_ack    in   1   one-cycle completion, only honoured while bus_req
//   bus_rdata  in  32   read data, valid with bus_ack
//
// Parameter TIMEOUT_CYC (1..255): number of REQ cycles without an ack after
// which the access is abandoned with an error.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        stall,
   output logic [31:0] mem_out,
   output logic        mem_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Wait-counter value seen in the last REQ cycle before giving up.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

   state_t      state_reg, state_next;
   logic [7:0]  wait_cnt_reg, wait_cnt_next;
   logic [31:2] addr_reg;      // low two bits are always zero for accepted requests
   logic [31:0] wdata_reg;
   logic        we_reg;
   logic [31:0] mem_out_reg;

   logic        cpu_req;
   logic        accept;

   assign cpu_req = cpu_rd | cpu_wr;
   assign accept  = (cpu_rd ^ cpu_wr) && (cpu_addr[1:0] == 2'b00);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 8'd0;
         addr_reg     <= '0;
         wdata_reg    <= 32'd0;
         we_reg       <= 1'b0;
         mem_out_reg  <= 32'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         // Holding registers only load when a request is actually accepted,
         // so the bus fields stay frozen for the whole REQ state.
         if (state_reg == IDLE && accept) begin
            addr_reg  <= cpu_addr[31:2];
            wdata_reg <= cpu_wdata;
            we_reg    <= cpu_wr;
         end
         // Read data is captured only on an ack seen while the bus is requested.
         if (state_reg == REQ && bus_ack && !we_reg) begin
            mem_out_reg <= bus_rdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      stall         = 1'b0;
      mem_err       = 1'b0;
      bus_req       = 1'b0;

      case (state_reg)
         IDLE: begin
            // IDLE is the only way into REQ, so clearing here clears on entry.
            wait_cnt_next = 8'd0;
            stall         = cpu_req;
            if (accept) begin
               state_next = REQ;
            end else if (cpu_req) begin
               state_next = ERR;
            end
         end
         REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            // An ack in the final allowed cycle still completes normally.
            if (bus_ack) begin
               state_next = DONE;
            end else if (wait_cnt_reg == LAST_WAIT) begin
               state_next = ERR;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         DONE: begin
            // cpu_* deliberately ignored: the pipeline advances this cycle.
            state_next = IDLE;
         end
         ERR: begin
            mem_err    = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_out   = mem_out_reg;
   assign bus_we    = we_reg;
   assign bus_addr  = {addr_reg, 2'b00};
   assign bus_wdata = wdata_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl -- randomized scoreboard bench for dmem_ctrl (TIMEOUT_CYC = 4).
// The driver issues accesses and pushes the expected outcome of each into a
// queue; an independent monitor pops an entry whenever an access completes
// (stall falls) and checks the bus fields on every cycle bus_req is high.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        stall;
   logic [31:0] mem_out;
   logic        mem_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   dmem_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .stall     (stall),
      .mem_out   (mem_out),
      .mem_err   (mem_err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        legal;
      bit        err;
      int        req_cycles;
      bit        we;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] mout;
   } exp_t;

   exp_t        exp_q[$];
   bit [31:0]   model_mem = 32'd0;   // last successfully read word
   int          vectors = 0;
   int          miscompares = 0;
   bit          skip = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one access. Returns just after the edge entering DONE/ERR.
   // With early=1 the request is raised during the DONE cycle left behind
   // by the previous access and must only be taken in the following IDLE.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay,
                        input logic [31:0] ack_rdata, input bit early);
      exp_t e;
      e.legal = (rd ^ wr) && (addr[1:0] == 2'b00);
      e.we    = wr;
      e.addr  = addr;
      e.wdata = wdata;
      if (!e.legal) begin
         e.err = 1'b1; e.req_cycles = 0;
      end else if (delay <= TO - 1) begin
         e.err = 1'b0; e.req_cycles = delay + 1;
         if (rd) model_mem = ack_rdata;
      end else begin
         e.err = 1'b1; e.req_cycles = TO;
      end
      e.mout = model_mem;
      exp_q.push_back(e);

      if (early) begin
         cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
         @(negedge clk);
         chk("stall_in_done", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
      end
      @(negedge clk);
      chk("stall_request_cycle", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      if (e.legal) begin
         for (int k = 0; k < TO && k <= delay; k++) begin
            bus_ack   = (k == delay);
            bus_rdata = (k == delay) ? ack_rdata : $urandom;
            @(posedge clk); #1;
         end
         bus_ack = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin
      bit   prev_stall = 1'b0;
      bit   prev_err = 1'b0;
      int   reqc = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (skip || rst) begin
            prev_stall = 1'b0; prev_err = 1'b0; reqc = 0;
         end else begin
            if (prev_err) chk("err_pulse_width", {31'd0, mem_err}, 32'd0);
            if (bus_req) begin
               reqc++;
               if (exp_q.size() == 0 || !exp_q[0].legal) begin
                  miscompares++;
                  $display("FAIL bus_req_unexpected: got bus_req=1 expected 0 at %0t", $time);
               end else begin
                  chk("bus_we", {31'd0, bus_we}, {31'd0, exp_q[0].we});
                  chk("bus_addr", bus_addr, exp_q[0].addr);
                  if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].wdata);
               end
            end
            if (prev_stall && !stall) begin
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL completion_unexpected: got completion expected none at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                  chk("mem_out", mem_out, e.mout);
                  chk("req_cycles", reqc, e.req_cycles);
                  $display("txn legal=%0d we=%0d addr=%h err=%0d mem_out=%h req_cycles=%0d",
                           e.legal, e.we, e.addr, mem_err, mem_out, reqc);
               end
               reqc = 0;
            end else if (mem_err) begin
               miscompares++;
               $display("FAIL mem_err_spurious: got 1 expected 0 at %0t", $time);
            end
            prev_stall = stall;
            prev_err   = mem_err;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int g;
      bit rd, wr, early;
      logic [31:0] a;

      rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_mem_out", mem_out, 32'd0);
      chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
      chk("rst_stall_idle", {31'd0, stall}, 32'd0);
      cpu_rd = 1'b1;
      #1 chk("rst_stall_follows_req", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      chk("rst_bus_req_held", {31'd0, bus_req}, 32'd0);
      cpu_rd = 1'b0; rst = 1'b0;

      // Directed: zero-wait read, delayed write, timeout, ack on last cycle
      issue(1, 0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 0);
      issue(0, 1, 32'h40, 32'h12345678, 3, 32'h0BADBEEF, 0);
      issue(1, 0, 32'h80, 32'h0, 99, 32'h11111111, 0);
      issue(1, 0, 32'h84, 32'h0, TO - 1, 32'h5A5A0001, 0);
      // Directed: misaligned and conflicting requests
      issue(1, 0, 32'h102, 32'h0, 0, 32'h22222222, 0);
      issue(1, 1, 32'h104, 32'h9, 0, 32'h33333333, 0);
      // Directed: back-to-back, then a request held through DONE
      issue(1, 0, 32'h200, 32'h0, 1, 32'hA5A5A5A5, 0);
      issue(0, 1, 32'h204, 32'hDEAD0001, 0, 32'h44444444, 0);
      issue(0, 1, 32'h208, 32'hDEAD0002, 2, 32'h55555555, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Directed: reset in the second REQ cycle, late ack afterwards
      skip = 1'b1;
      cpu_rd = 1'b1; cpu_addr = 32'h300;
      @(posedge clk); #1;
      cpu_rd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_bus_req_before", {31'd0, bus_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77777777;
      @(negedge clk);
      chk("rst_mid_req_bus_req_after", {31'd0, bus_req}, 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("rst_mid_req_mem_out", mem_out, 32'd0);
      chk("rst_mid_req_mem_err", {31'd0, mem_err}, 32'd0);
      model_mem = 32'd0;
      @(posedge clk); #1;
      skip = 1'b0;

      // Randomized traffic with idle gaps carrying stray acks
      for (int n = 0; n < 300; n++) begin
         g  = $urandom_range(0, 2);
         repeat (g) begin
            bus_ack = $urandom_range(0, 1); bus_rdata = $urandom;
            @(posedge clk); #1;
         end
         bus_ack = 1'b0;
         early = (g == 0) && ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       begin rd = 1; wr = 1; end
            1,2,3,4: begin rd = 1; wr = 0; end
            default: begin rd = 0; wr = 1; end
         endcase
         a = {$urandom_range(0, 255), 2'b00} + 32'h1000;
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         issue(rd, wr, a, $urandom, $urandom_range(0, 5), $urandom, early);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_txns: got %0d outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
